ram_io: RTL and testbench

Byte-wide memory and I/O target on the far side of the `risc` core's external bus (`rom_a`, `rom_wr`, `rom_wn`, `rom_rn`).
- Serves core fetches, loads and stores from a single-port synchronous RAM.
- Decodes a small I/O window: a byte-output FIFO drained by a host/UART-side consumer, plus a sticky halt flag.
- Sits between the core top level and the board/testbench; the core has no stall input, so this block never back-pressures the bus.

---
 rtl/ram_io.sv | 112 +++++++++++
 tb/tb_ram_io.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_io.sv
// Byte-wide RAM plus I/O window (output FIFO, sticky halt) serving the risc external bus.
// Optional macro RAM_IO_STATUS_EN makes I/O reads return FIFO/halt status instead of zero.
module ram_io #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_a,
    input  logic        rom_wr,
    input  logic [7:0]  rom_wn,
    output logic [7:0]  rom_rn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       mem      [0:(1 << ADDR_W) - 1];
    logic [7:0]       fifo_mem [0:FIFO_DEPTH - 1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic              io_sel;
    logic [ADDR_W-1:0] idx;
    logic              push_req;
    logic              halt_wr;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [7:0]        io_rdata;

    assign io_sel   = (rom_a[31:16] == 16'h0003);
    assign idx      = rom_a[ADDR_W-1:0];
    assign push_req = rom_wr && io_sel && (rom_a[15:0] == 16'h0000);
    assign halt_wr  = rom_wr && io_sel && (rom_a[15:0] == 16'h0004);
    assign pop      = tx_valid && tx_ready;
    assign full     = (count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    assign tx_valid = (count != '0);
    assign tx_data  = fifo_mem[rd_ptr];

`ifdef RAM_IO_STATUS_EN
    logic [4:0] count_ext;
    assign count_ext = 5'(count);

    always_comb begin
        io_rdata = 8'h00;
        case (rom_a[15:0])
            16'h0000: io_rdata = {ovf, 2'b00, count_ext};
            16'h0004: io_rdata = {7'b0, halt};
            default:  io_rdata = 8'h00;
        endcase
    end
`else
    assign io_rdata = 8'h00;
`endif

    // Storage arrays carry no reset; a reset only clears the bookkeeping.
    always_ff @(posedge clk) begin
        if (rom_wr && !io_sel) begin
            mem[idx] <= rom_wn;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rom_wn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_rn <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            halt   <= 1'b0;
        end else begin
            if (!rom_wr) begin
                rom_rn <= io_sel ? io_rdata : mem[idx];
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            ovf <= ovf | drop;
            if (halt_wr) begin
                halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_io.sv
// Directed self-checking bench for ram_io (default build; status reads checked when RAM_IO_STATUS_EN is defined).
module tb_ram_io;

    logic        clk;
    logic        rst;
    logic [31:0] rom_a;
    logic        rom_wr;
    logic [7:0]  rom_wn;
    logic [7:0]  rom_rn;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    int n_vec;
    int n_err;

    ram_io #(.ADDR_W(17), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_a    (rom_a),
        .rom_wr   (rom_wr),
        .rom_wn   (rom_wn),
        .rom_rn   (rom_rn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt     (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        rom_wr = wr;
        rom_a  = a;
        rom_wn = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        tx_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        #12;
        n_vec++; if (rom_rn !== 8'h00) begin n_err++; $display("FAIL reset_rom_rn got %h exp 00", rom_rn); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b exp 0", halt); end
        @(negedge clk);
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_ram();
        drive(1'b1, 32'h0000_0010, 8'hA5); cycle();
        drive(1'b0, 32'h0000_0010, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'hA5) begin n_err++; $display("FAIL ram_read got %h exp a5", rom_rn); end
        drive(1'b0, 32'h0002_0010, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'hA5) begin n_err++; $display("FAIL ram_alias got %h exp a5", rom_rn); end
        drive(1'b1, 32'h0000_0011, 8'h5A); cycle();
        n_vec++; if (rom_rn !== 8'hA5) begin n_err++; $display("FAIL ram_hold_on_write got %h exp a5", rom_rn); end
        drive(1'b0, 32'h0000_0011, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'h5A) begin n_err++; $display("FAIL ram_wr_then_rd got %h exp 5a", rom_rn); end
        drive(1'b0, 32'h0003_0008, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'h00) begin n_err++; $display("FAIL io_unmapped_read got %h exp 00", rom_rn); end
        drive(1'b1, 32'h0003_0008, 8'h33); cycle();
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL io_unmapped_write got tx_valid %b exp 0", tx_valid); end
        drive(1'b0, 32'h0000_0010, 8'h00); cycle();
    endtask

    task automatic test_fifo_order();
        tx_ready = 1'b0;
        drive(1'b1, 32'h0003_0000, 8'h48); cycle();
        n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL fifo_first_valid got %b exp 1", tx_valid); end
        n_vec++; if (tx_data !== 8'h48) begin n_err++; $display("FAIL fifo_first_data got %h exp 48", tx_data); end
        drive(1'b1, 32'h0003_0000, 8'h69); cycle();
        drive(1'b0, 32'h0000_0000, 8'h00);
        n_vec++; if (tx_data !== 8'h48) begin n_err++; $display("FAIL fifo_head_kept got %h exp 48", tx_data); end
        tx_ready = 1'b1;
        cycle();
        n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin
            n_err++; $display("FAIL fifo_second got valid %b data %h exp 1 69", tx_valid, tx_data);
        end
        cycle();
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL fifo_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i)); cycle();
        end
        drive(1'b0, 32'h0003_0000, 8'h00); cycle();
`ifdef RAM_IO_STATUS_EN
        n_vec++; if (rom_rn !== 8'h90) begin n_err++; $display("FAIL ovf_status got %h exp 90", rom_rn); end
`else
        n_vec++; if (rom_rn !== 8'h00) begin n_err++; $display("FAIL ovf_status got %h exp 00", rom_rn); end
`endif
        drive(1'b0, 32'h0000_0000, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                n_err++; $display("FAIL ovf_drain[%0d] got valid %b data %h exp 1 %h", i, tx_valid, tx_data, 8'(i));
            end
            cycle();
        end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped got valid %b data %h exp 0", tx_valid, tx_data); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h0003_0000, 8'h20 + 8'(i)); cycle();
        end
        tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h55); cycle();
        tx_ready = 1'b0;
        drive(1'b0, 32'h0003_0000, 8'h00); cycle();
`ifdef RAM_IO_STATUS_EN
        n_vec++; if (rom_rn !== 8'h10) begin n_err++; $display("FAIL full_pp_status got %h exp 10", rom_rn); end
`else
        n_vec++; if (rom_rn !== 8'h00) begin n_err++; $display("FAIL full_pp_status got %h exp 00", rom_rn); end
`endif
        drive(1'b0, 32'h0000_0000, 8'h00);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 16) ? 8'h55 : 8'h20 + 8'(i);
            n_vec++; if (tx_valid !== 1'b1 || tx_data !== exp_d) begin
                n_err++; $display("FAIL full_pp_drain[%0d] got valid %b data %h exp 1 %h", i, tx_valid, tx_data, exp_d);
            end
            cycle();
        end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL full_pp_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_halt();
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL halt_pre got %b exp 0", halt); end
        drive(1'b1, 32'h0003_0004, 8'h77); cycle();
        n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set got %b exp 1", halt); end
        drive(1'b0, 32'h0000_0000, 8'h00);
        repeat (3) cycle();
        n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_sticky got %b exp 1", halt); end
`ifdef RAM_IO_STATUS_EN
        drive(1'b0, 32'h0003_0004, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'h01) begin n_err++; $display("FAIL halt_status got %h exp 01", rom_rn); end
`endif
        drive(1'b1, 32'h0003_0000, 8'hC1); cycle();
        drive(1'b1, 32'h0003_0000, 8'hC2); cycle();
        drive(1'b0, 32'h0000_0010, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'hA5 || tx_valid !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_state got rom_rn %h valid %b exp a5 1", rom_rn, tx_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL async_rst_halt got %b exp 0", halt); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_tx_valid got %b exp 0", tx_valid); end
        n_vec++; if (rom_rn !== 8'h00) begin n_err++; $display("FAIL async_rst_rom_rn got %h exp 00", rom_rn); end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0000_0010, 8'h00); cycle();
        n_vec++; if (rom_rn !== 8'hA5) begin n_err++; $display("FAIL ram_survives_rst got %h exp a5", rom_rn); end
        n_vec++; if (halt !== 1'b0 || tx_valid !== 1'b0) begin
            n_err++; $display("FAIL post_rst_state got halt %b valid %b exp 0 0", halt, tx_valid);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ram();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
